// File: rtl/ga23_pkg.sv
// Shared types and constants for the GA23 tile fetch path.
package ga23_pkg;

  // Bit positions inside the tilemap attribute word (word 1).
  localparam int unsigned ATTR_PAL_LSB   = 0;
  localparam int unsigned ATTR_PRIO_LSB  = 4;
  localparam int unsigned ATTR_FLIPX_BIT = 6;
  localparam int unsigned ATTR_FLIPY_BIT = 7;

  // Legacy state encodings, kept as named constants for code that
  // still compares against raw state values.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ATTR0 = 3'd1;
  localparam logic [2:0] ST_ATTR1 = 3'd2;
  localparam logic [2:0] ST_ROM   = 3'd3;
  localparam logic [2:0] ST_READY = 3'd4;

  typedef enum logic [2:0] {
    FS_IDLE  = ST_IDLE,
    FS_ATTR0 = ST_ATTR0,
    FS_ATTR1 = ST_ATTR1,
    FS_ROM   = ST_ROM,
    FS_READY = ST_READY
  } fetch_state_t;

  typedef struct packed {
    logic       flip_y;
    logic       flip_x;
    logic [1:0] prio;
    logic [3:0] palette;
  } tile_attr_t;

  // Unpack the low byte of an attribute word.
  function automatic tile_attr_t decode_attr(input logic [7:0] w);
    tile_attr_t a;
    a.palette = w[ATTR_PAL_LSB +: 4];
    a.prio    = w[ATTR_PRIO_LSB +: 2];
    a.flip_x  = w[ATTR_FLIPX_BIT];
    a.flip_y  = w[ATTR_FLIPY_BIT];
    return a;
  endfunction

endpackage

// File: rtl/ga23_tile_fetch.sv
// Per-layer tile fetch sequencer: VRAM code/attr read, ROM row fetch,
// and one load pulse per 8-pixel slot into the layer's pixel shifter.
module ga23_tile_fetch
  import ga23_pkg::*;
#(
  parameter int unsigned TILES_PER_LINE = 42
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ce_pix,
  input  logic        line_start,
  input  logic [8:0]  vcnt,
  input  logic        vblank,
  input  logic        enable,
  input  logic [9:0]  scroll_x,
  input  logic [9:0]  scroll_y,
  input  logic [1:0]  map_sel,
  output logic        vram_req,
  output logic [14:0] vram_addr,
  input  logic        vram_ack,
  input  logic [15:0] vram_data,
  output logic        rom_req,
  output logic [20:0] rom_addr,
  input  logic        rom_ack,
  input  logic [31:0] rom_data,
  output logic        sh_load,
  output logic        sh_reverse,
  output logic [31:0] sh_row,
  output logic [3:0]  sh_palette,
  output logic [1:0]  sh_prio,
  output logic [2:0]  sh_offset,
  output logic        underrun
);

  localparam int unsigned TL_W = $clog2(TILES_PER_LINE + 1);
  localparam logic [TL_W-1:0] TL_INIT = TL_W'(TILES_PER_LINE);
  localparam logic [TL_W-1:0] TL_ONE  = TL_W'(1);

  fetch_state_t    state, state_n;
  logic            discard, discard_n;
  logic            start_fetch;
  logic            line_active;
  logic [2:0]      slot_cnt;
  logic [TL_W-1:0] tiles_left;
  logic [5:0]      col, col_n;
  logic [8:0]      yy;
  logic [1:0]      map_q;
  logic [13:0]     vbase;
  logic [15:0]     code_q;
  logic [2:0]      fy_q;
  tile_attr_t      attr_q;
  logic [31:0]     row_q;

  logic ls, boundary, busy, ack_now, fetch_ok, more_tiles;
  logic unused_bits;

  assign unused_bits = ^{scroll_x[9], scroll_y[9], attr_q.flip_y};

  // Requests are pure state decodes; the fetch address is frozen in vbase
  // and code_q/fy_q so it cannot move while a handshake is open.
  assign vram_req  = (state == FS_ATTR0) || (state == FS_ATTR1);
  assign vram_addr = {vbase, (state == FS_ATTR1)};
  assign rom_req   = (state == FS_ROM);
  assign rom_addr  = {code_q, fy_q, 2'b00};

  // Slot timing and handshake qualifiers.
  always_comb begin
    ls         = line_start & ce_pix;
    boundary   = ce_pix & (slot_cnt == 3'd7) & line_active &
                 (tiles_left != '0) & ~line_start;
    busy       = (state == FS_ATTR0) || (state == FS_ATTR1) || (state == FS_ROM);
    ack_now    = 1'b0;
    case (state)
      FS_ATTR0, FS_ATTR1: ack_now = vram_ack;
      FS_ROM:             ack_now = rom_ack;
      default:            ack_now = 1'b0;
    endcase
    fetch_ok   = line_active & (tiles_left != '0) & enable;
    more_tiles = line_active & (tiles_left > TL_ONE) & enable;
    col_n      = boundary ? col + 6'd1 : col;
  end

  // Next-state: normal handshake progression, then discarded-fetch
  // completion, then slot boundary / line abort which take priority.
  // An open handshake is never cut short; it is marked for discard and the
  // FSM restarts once its ack lands.
  always_comb begin
    state_n     = state;
    discard_n   = discard;
    start_fetch = 1'b0;
    case (state)
      FS_IDLE:  if (fetch_ok) begin
                  state_n     = FS_ATTR0;
                  start_fetch = 1'b1;
                end
      FS_ATTR0: if (vram_ack) state_n = FS_ATTR1;
      FS_ATTR1: if (vram_ack) state_n = FS_ROM;
      FS_ROM:   if (rom_ack)  state_n = FS_READY;
      default:  state_n = state;
    endcase
    if (busy && discard && ack_now) begin
      discard_n = 1'b0;
      if (fetch_ok) begin
        state_n     = FS_ATTR0;
        start_fetch = 1'b1;
      end else begin
        state_n     = FS_IDLE;
        start_fetch = 1'b0;
      end
    end
    if (ls || boundary) begin
      if (busy && !ack_now) begin
        discard_n   = 1'b1;
        state_n     = state;
        start_fetch = 1'b0;
      end else begin
        discard_n = 1'b0;
        if (boundary && more_tiles) begin
          state_n     = FS_ATTR0;
          start_fetch = 1'b1;
        end else begin
          state_n     = FS_IDLE;
          start_fetch = 1'b0;
        end
      end
    end
  end

  // Line latches, slot counter, fetch staging and shifter outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= FS_IDLE;
      discard     <= 1'b0;
      line_active <= 1'b0;
      slot_cnt    <= '0;
      tiles_left  <= '0;
      col         <= '0;
      yy          <= '0;
      map_q       <= '0;
      vbase       <= '0;
      code_q      <= '0;
      fy_q        <= '0;
      attr_q      <= '0;
      row_q       <= '0;
      sh_load     <= 1'b0;
      sh_reverse  <= 1'b0;
      sh_row      <= '0;
      sh_palette  <= '0;
      sh_prio     <= '0;
      sh_offset   <= '0;
      underrun    <= 1'b0;
    end else begin
      state   <= state_n;
      discard <= discard_n;

      if (ls) begin
        col         <= scroll_x[8:3];
        yy          <= vcnt + scroll_y[8:0];
        map_q       <= map_sel;
        sh_offset   <= scroll_x[2:0];
        slot_cnt    <= '0;
        tiles_left  <= TL_INIT;
        line_active <= ~vblank;
      end else begin
        if (ce_pix)   slot_cnt   <= slot_cnt + 3'd1;
        if (boundary) tiles_left <= tiles_left - TL_ONE;
        col <= col_n;
      end

      if (start_fetch) vbase <= {map_q, yy[8:3], col_n};

      if (state == FS_ATTR0 && vram_ack) code_q <= vram_data;
      if (state == FS_ATTR1 && vram_ack) begin
        attr_q <= decode_attr(vram_data[7:0]);
        fy_q   <= yy[2:0] ^ {3{vram_data[ATTR_FLIPY_BIT]}};
      end
      if (state == FS_ROM && rom_ack && !discard) row_q <= rom_data;

      sh_load  <= boundary;
      underrun <= boundary & enable & (state != FS_READY);
      if (boundary) begin
        if (enable && state == FS_READY) begin
          sh_row     <= row_q;
          sh_palette <= attr_q.palette;
          sh_prio    <= attr_q.prio;
          sh_reverse <= attr_q.flip_x;
        end else begin
          sh_row     <= '0;
          sh_palette <= '0;
          sh_prio    <= '0;
          sh_reverse <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ga23_tile_fetch.sv
// Directed bench for ga23_tile_fetch with behavioural VRAM/ROM responders.
module tb_ga23_tile_fetch;

  logic        clk, reset, ce_pix, line_start, vblank, enable;
  logic [8:0]  vcnt;
  logic [9:0]  scroll_x, scroll_y;
  logic [1:0]  map_sel;
  logic        vram_req, vram_ack, rom_req, rom_ack;
  logic [14:0] vram_addr;
  logic [15:0] vram_data;
  logic [20:0] rom_addr;
  logic [31:0] rom_data;
  logic        sh_load, sh_reverse, underrun;
  logic [31:0] sh_row;
  logic [3:0]  sh_palette;
  logic [1:0]  sh_prio;
  logic [2:0]  sh_offset;

  ga23_tile_fetch #(.TILES_PER_LINE(42)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix), .line_start(line_start),
    .vcnt(vcnt), .vblank(vblank), .enable(enable),
    .scroll_x(scroll_x), .scroll_y(scroll_y), .map_sel(map_sel),
    .vram_req(vram_req), .vram_addr(vram_addr), .vram_ack(vram_ack),
    .vram_data(vram_data), .rom_req(rom_req), .rom_addr(rom_addr),
    .rom_ack(rom_ack), .rom_data(rom_data), .sh_load(sh_load),
    .sh_reverse(sh_reverse), .sh_row(sh_row), .sh_palette(sh_palette),
    .sh_prio(sh_prio), .sh_offset(sh_offset), .underrun(underrun)
  );

  typedef struct {
    logic [31:0] row;
    logic [3:0]  pal;
    logic [1:0]  prio;
    logic        rev;
    logic        urun;
    int          ce;
  } load_t;

  int n_checks = 0;
  int n_errors = 0;
  int ce_cnt = 0;
  int urun_cnt = 0;
  int req_seen = 0;
  int rom_txn = 0;
  int rom_cnt = -1;
  int rom_unstable = 0;
  int slow_txn = -1;
  int slow_clks = 0;
  logic        vram_hold = 1'b0;
  logic [15:0] attr_word = 16'h0000;
  logic [20:0] rom_hold_addr;
  logic [14:0] vq[$];
  logic [20:0] rq[$];
  load_t       loads[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] vram_model(input logic [14:0] a);
    return a[0] ? attr_word : {2'b10, a[14:1]};
  endfunction

  function automatic logic [31:0] rom_model(input logic [20:0] a);
    return {11'h5A5, a};
  endfunction

  function automatic logic [20:0] exp_raddr(input logic [1:0] m, input logic [5:0] t,
                                            input logic [5:0] c, input logic [2:0] fy);
    return {2'b10, m, t, c, fy, 2'b00};
  endfunction

  function automatic logic [31:0] exp_row(input logic [1:0] m, input logic [5:0] t,
                                          input logic [5:0] c, input logic [2:0] fy);
    return rom_model(exp_raddr(m, t, c, fy));
  endfunction

  function automatic logic [31:0] col_of(input logic [14:0] a);
    return {26'd0, a[6:1]};
  endfunction

  function automatic logic [31:0] trow_of(input logic [14:0] a);
    return {26'd0, a[12:7]};
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    ce_pix = 1'b0;
    forever #10 ce_pix = ~ce_pix;
  end

  always @(posedge clk) if (ce_pix) ce_cnt++;

  always @(negedge clk) begin
    if (sh_load) loads.push_back('{sh_row, sh_palette, sh_prio, sh_reverse, underrun, ce_cnt});
    if (underrun) urun_cnt++;
  end

  // VRAM responder: zero-wait unless an attribute read is being held.
  initial begin
    vram_ack  = 1'b0;
    vram_data = '0;
    forever begin
      @(posedge clk); #1;
      vram_ack = 1'b0;
      if (vram_req) req_seen++;
      if (vram_req && !(vram_hold && vram_addr[0])) begin
        vram_ack  = 1'b1;
        vram_data = vram_model(vram_addr);
        if (!vram_addr[0]) vq.push_back(vram_addr);
      end
    end
  end

  // ROM responder: zero-wait, except transaction slow_txn waits slow_clks.
  initial begin
    rom_ack  = 1'b0;
    rom_data = '0;
    forever begin
      @(posedge clk); #1;
      rom_ack = 1'b0;
      if (rom_req) begin
        if (rom_cnt < 0) begin
          rom_cnt       = (rom_txn == slow_txn) ? slow_clks : 0;
          rom_hold_addr = rom_addr;
        end else if (rom_addr !== rom_hold_addr) begin
          rom_unstable++;
        end
        if (rom_cnt == 0) begin
          rom_ack  = 1'b1;
          rom_data = rom_model(rom_addr);
          rq.push_back(rom_addr);
          rom_txn++;
          rom_cnt = -1;
        end else begin
          rom_cnt--;
        end
      end
    end
  end

  task automatic start_line(output int ls_ce);
    @(posedge clk iff ce_pix); #2;
    line_start = 1'b1;
    @(posedge clk iff ce_pix); #2;
    line_start = 1'b0;
    ls_ce = ce_cnt;
    vq.delete();
    rq.delete();
    loads.delete();
    urun_cnt = 0;
    req_seen = 0;
  endtask

  task automatic wait_ce(input int target);
    while (ce_cnt < target) @(negedge clk);
  endtask

  task automatic quiesce();
    int dummy;
    vblank = 1'b1;
    start_line(dummy);
    vblank = 1'b0;
    repeat (30) @(posedge clk);
    #2;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int ls, lsa, lsb, nbad, waited;
    logic [14:0] a;

    reset = 1'b1; line_start = 1'b0; vcnt = '0; vblank = 1'b0; enable = 1'b1;
    scroll_x = '0; scroll_y = '0; map_sel = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_vram_req", 32'(vram_req), 0);
    check("rst_rom_req", 32'(rom_req), 0);
    check("rst_sh_load", 32'(sh_load), 0);
    check("rst_sh_row", sh_row, 0);
    check("rst_sh_offset", 32'(sh_offset), 0);
    check("rst_underrun", 32'(underrun), 0);
    reset = 1'b0;

    // Zero-wait memory, full line.
    map_sel = 2'd1; scroll_x = 10'h013; scroll_y = '0; vcnt = '0; attr_word = 16'h0000;
    start_line(ls);
    wait_ce(ls + 8 * 44);
    check("zw_offset", 32'(sh_offset), 3);
    check("zw_loads", 32'(loads.size()), 42);
    check("zw_vram_reads", 32'(vq.size()), 42);
    a = vq[0];
    check("zw_first_col", col_of(a), 2);
    check("zw_first_trow", trow_of(a), 0);
    check("zw_first_load_ce", 32'(loads[0].ce), 32'(ls + 8));
    nbad = 0;
    for (int i = 0; i < loads.size() && i < 42; i++) begin
      if (loads[i].row !== exp_row(2'd1, 6'd0, 6'((2 + i) % 64), 3'd0)) nbad++;
      if (i > 0 && (loads[i].ce - loads[i-1].ce) != 8) nbad++;
    end
    check("zw_rows_and_spacing", 32'(nbad), 0);
    check("zw_underruns", 32'(urun_cnt), 0);

    // Flip-X/Y attribute.
    quiesce();
    map_sel = 2'd0; scroll_x = '0; vcnt = 9'd5; attr_word = 16'h00C5;
    start_line(ls);
    wait_ce(ls + 10);
    check("flip_fy", {29'd0, rq[0][4:2]}, 2);
    check("flip_rev", 32'(loads[0].rev), 1);
    check("flip_pal", 32'(loads[0].pal), 5);
    check("flip_prio", 32'(loads[0].prio), 0);
    check("flip_row", loads[0].row, exp_row(2'd0, 6'd0, 6'd0, 3'd2));

    // Column and row wrap.
    quiesce();
    scroll_x = 10'h3F8; vcnt = 9'h1F8; scroll_y = 10'h008; attr_word = 16'h0000;
    start_line(ls);
    wait_ce(ls + 26);
    a = vq[0]; check("wrap_col0", col_of(a), 63);
    check("wrap_trow", trow_of(a), 0);
    a = vq[1]; check("wrap_col1", col_of(a), 0);
    a = vq[2]; check("wrap_col2", col_of(a), 1);
    check("wrap_row1", loads[1].row, exp_row(2'd0, 6'd0, 6'd0, 3'd0));

    // Underrun on tile 4.
    quiesce();
    map_sel = 2'd2; scroll_x = '0; scroll_y = '0; vcnt = 9'h010; attr_word = 16'h0013;
    slow_txn = rom_txn + 4; slow_clks = 20;
    start_line(ls);
    wait_ce(ls + 8 * 7 + 2);
    slow_txn = -1;
    check("ur_t3_row", loads[3].row, exp_row(2'd2, 6'd2, 6'd3, 3'd0));
    check("ur_t3_flag", 32'(loads[3].urun), 0);
    check("ur_t4_row", loads[4].row, 0);
    check("ur_t4_flag", 32'(loads[4].urun), 1);
    check("ur_t4_pal", 32'(loads[4].pal), 0);
    check("ur_t5_row", loads[5].row, exp_row(2'd2, 6'd2, 6'd5, 3'd0));
    check("ur_t5_pal", 32'(loads[5].pal), 3);
    check("ur_t5_prio", 32'(loads[5].prio), 1);
    a = vq[5]; check("ur_t5_col", col_of(a), 5);
    check("ur_t5_raddr", 32'(rq[5]), 32'(exp_raddr(2'd2, 6'd2, 6'd5, 3'd0)));
    check("ur_count", 32'(urun_cnt), 1);

    // Line restart during a pending ROM fetch, on a slot boundary.
    quiesce();
    map_sel = 2'd0; scroll_x = '0; vcnt = '0; attr_word = 16'h0000;
    slow_txn = rom_txn + 1; slow_clks = 20;
    start_line(lsa);
    wait_ce(lsa + 14);
    slow_txn = -1;
    scroll_x = 10'h028;
    start_line(lsb);
    check("ab_boundary_align", 32'(lsb), 32'(lsa + 16));
    wait_ce(lsb + 10);
    nbad = 0;
    foreach (loads[i]) if (loads[i].ce == lsb) nbad++;
    check("ab_no_load", 32'(nbad), 0);
    check("ab_first_load_ce", 32'(loads[0].ce), 32'(lsb + 8));
    check("ab_first_row", loads[0].row, exp_row(2'd0, 6'd0, 6'd5, 3'd0));
    a = vq[0]; check("ab_new_col", col_of(a), 5);
    check("ab_late_ack", 32'(rq[0]), 32'(exp_raddr(2'd0, 6'd0, 6'd1, 3'd0)));
    check("ab_underruns", 32'(urun_cnt), 0);
    check("rom_addr_stable", 32'(rom_unstable), 0);

    // Reset in the middle of the attribute read.
    quiesce();
    scroll_x = 10'h005; vram_hold = 1'b1;
    start_line(ls);
    check("rst2_pre_offset", 32'(sh_offset), 5);
    waited = 0;
    while (!(vram_req && vram_addr[0]) && waited < 100) begin
      @(posedge clk); #1;
      waited++;
    end
    check("rst2_reached_attr1", 32'(vram_req && vram_addr[0]), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rst2_vram_req", 32'(vram_req), 0);
    check("rst2_vram_addr", 32'(vram_addr), 0);
    check("rst2_rom_req", 32'(rom_req), 0);
    check("rst2_sh_offset", 32'(sh_offset), 0);
    check("rst2_outputs", {sh_load, sh_reverse, underrun, sh_palette, sh_prio}, 0);
    reset = 1'b0; vram_hold = 1'b0;

    // Layer disabled: loads of zero, no requests, no underrun.
    enable = 1'b0; scroll_x = '0; attr_word = 16'h00C5;
    start_line(ls);
    wait_ce(ls + 26);
    check("dis_requests", 32'(req_seen), 0);
    check("dis_loads", 32'(loads.size()), 3);
    nbad = 0;
    foreach (loads[i]) if (loads[i].row !== 32'd0 || loads[i].pal !== 4'd0) nbad++;
    check("dis_rows_zero", 32'(nbad), 0);
    check("dis_underruns", 32'(urun_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
